down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
- Synchronous, loadable down-counter and interval timer.
- It is the counting-down counterpart to the team's ripple up-counter.
- An internal prescaler derives a count tick from the board clock, and the block counts a loaded value down to zero.
- It flags terminal count and can auto-reload, so it serves as a periodic event source for lab designs and drives LEDs or other blocks directly.

Parameters:
WIDTH, 4, width of count and load value
DIV, 4, clock cycles per count tick (>=1; board builds use 50_000_000)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous abort: return to IDLE, count=0
load  input  1  single-cycle strobe: capture load_value and start
load_value  input  WIDTH  start/reload value
enable  input  1  count gate; low freezes prescaler and count
auto_reload  input  1  1: reload on terminal count and keep running
count  output  WIDTH  current count (registered)
tc_pulse  output  1  one-cycle pulse on terminal count (registered)
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, reload_reg=0, prescaler=0, tc_pulse=0, busy=0, done=0.
- States: IDLE, RUN, DONE. busy=(state==RUN) and done=(state==DONE), both decoded from the state register.
- Priority per cycle: clear > load > tick. This priority is the same in every state.
- clear:
  - state=IDLE, count=0, prescaler=0, tc_pulse=0.
  - reload_reg is retained.
- load:
  - count=load_value, reload_reg=load_value, prescaler=0.
  - Next state is RUN if load_value!=0, else DONE. Loading 0 produces no tc_pulse.
  - load mid-RUN restarts the count and discards any tick in the same cycle.
- Prescaler:
  - Width is max(1,$clog2(DIV)).
  - It advances only in RUN with enable=1.
  - tick=1 when prescaler==DIV-1; the prescaler then wraps to 0.
  - With DIV=1, tick=1 on every enabled RUN cycle.
- On tick in RUN:
  - count>1: count decrements by 1.
  - count==1 and auto_reload=0: count=0, tc_pulse=1 for the next cycle, state=DONE.
  - count==1 and auto_reload=1: count=reload_reg (0 is never shown), tc_pulse=1, state stays RUN.
  - Period = reload_reg*DIV cycles.
- auto_reload is sampled at the tick cycle only.
- enable=0 in RUN: prescaler, count and state hold. Resuming continues from the frozen prescaler value; there is no restart.
- IDLE and DONE: prescaler is held at 0 and count holds. Only load or clear change state.
- tc_pulse is never high for two consecutive cycles unless DIV=1 with reload_reg=1. In that case it is high every cycle while enabled.
- All arithmetic is unsigned. count never wraps below 0.
- Latency: count changes on the clock edge where tick=1. tc_pulse is valid in the cycle following that edge, coincident with the new count value.

Decomposition:
- Shared package/header holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a default DIV for board builds.
- One sub-module, tick_prescaler (parameters DIV):
  - ports clock, reset, clr, en, tick;
  - replaces the team's divided-clock approach with a clock enable. The design has no derived clocks.
- The FSM and count register stay in down_counter_timer.

Test Plan:
All scenarios use WIDTH=4, DIV=4.
1. Reset: hold reset=0 with random inputs -> count=0, tc_pulse=0, busy=0, done=0. Release, then idle 10 cycles -> no change.
2. One-shot: load=1 with load_value=3 at edge E0, enable=1, auto_reload=0 -> busy=1 from E0. Count is 2 at E4, 1 at E8, 0 at E12. tc_pulse high for exactly one cycle after E12, then done=1 and busy=0; count stays 0 for 20 cycles.
3. Auto-reload: load 2 with auto_reload=1 -> count sequence 2,1,2,1,... changing every 4 cycles. tc_pulse fires once every 8 cycles and count never reads 0.
4. Pause: load 5, drop enable for 7 cycles at prescaler=2 -> count and prescaler frozen. After re-enable, the next decrement occurs 1 cycle later and the total run time grows by exactly 7 cycles.
5. Priority: clear and load asserted together mid-RUN -> IDLE, count=0. load coincident with tick -> count=load_value with no decrement. load_value=0 -> done=1 next cycle, no tc_pulse.
6. Async reset: assert reset=0 mid-RUN between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter timer: state encoding, board default
// tick divider and the prescaler width helper.
package down_counter_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Board clock is 50 MHz, so this gives one count tick per second.
    localparam int DEFAULT_DIV = 50_000_000;

    // A divide-by-1 prescaler still needs one bit of storage to stay legal.
    function automatic int prescaler_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/down_counter_timer_tick_prescaler.sv
// Clock-enable prescaler: produces a one-cycle tick every DIV enabled cycles.
// The rest of the design stays on the single board clock.
module tick_prescaler
    import down_counter_timer_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = prescaler_width(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] phase;

    // Tick on the last phase of an enabled cycle; clr suppresses it.
    assign tick = en && !clr && (phase == LAST);

    // Phase counter: cleared on request, frozen when not enabled, wraps at DIV-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter / interval timer with terminal-count pulse and optional
// auto-reload. Priority every cycle is clear, then load, then tick.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc_pulse,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic             tc_next;
    logic             tick;
    logic             pre_clr;
    logic             pre_en;

    // The prescaler only runs while counting; any clear or load restarts its phase.
    assign pre_en  = (state == ST_RUN) && enable;
    assign pre_clr = clear || load || (state != ST_RUN);

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    // State, count, reload value and terminal-count pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc_pulse   <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_reg <= reload_next;
            tc_pulse   <= tc_next;
        end
    end

    // Next-state logic: clear beats load beats tick, in every state.
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else if (load) begin
            count_next  = load_value;
            reload_next = load_value;
            state_next  = (load_value != '0) ? ST_RUN : ST_DONE;
        end else begin
            case (state)
                ST_RUN: begin
                    if (tick) begin
                        if (count > ONE) begin
                            count_next = count - ONE;
                        end else if (count == ONE) begin
                            tc_next = 1'b1;
                            if (auto_reload) begin
                                count_next = reload_reg;
                            end else begin
                                count_next = '0;
                                state_next = ST_DONE;
                            end
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_next = state;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule
